video_timing_gen: RTL

Source-side video timing generator for the HDMI overlay path. Produces the `vs`/`hs`/`de` stream and matching pixel coordinates that the glyph overlay and downstream HDMI transmitter consume. It runs in the `pixel_clk` domain. Start/stop is frame-aligned, so a partial frame is never emitted.

---
 rtl/video_timing_gen.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// video_timing_gen: source-side vs/hs/de generator with active-pixel coordinates.
// Define VTG_COLORBAR_EN to add the rgb_out colour-bar test pattern.
module video_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        vs_out,
  output logic        hs_out,
  output logic        de_out,
  output logic [11:0] pixel_x,
  output logic [11:0] pixel_y,
  output logic        frame_start,
  output logic        busy
`ifdef VTG_COLORBAR_EN
  ,
  output logic [23:0] rgb_out
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] H_SS   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SE   = 12'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] V_SS   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SE   = 12'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  // START is a one-cycle arming state so the counters enter RUN at (0,0)
  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] h_q, h_d;
  logic [11:0] v_q, v_d;

  logic        vs_q, vs_d;
  logic        hs_q, hs_d;
  logic        de_q, de_d;
  logic [11:0] px_q, px_d;
  logic [11:0] py_q, py_d;
  logic        fs_q, fs_d;
  logic        busy_q, busy_d;

  logic live;
  logic h_wrap;
  logic eof;
  logic hs_in;
  logic vs_in;

  assign live   = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign h_wrap = (h_q == H_LAST);
  assign eof    = live && h_wrap && (v_q == V_LAST);
  assign hs_in  = live && (h_q >= H_SS) && (h_q < H_SE);
  assign vs_in  = live && (v_q >= V_SS) && (v_q < V_SE);

  // Run/stop sequencing; stops only on a frame boundary
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (en) state_d = S_START;
      end
      S_START: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (!en) state_d = eof ? S_IDLE : S_DRAIN;
      end
      S_DRAIN: begin
        if (en)       state_d = S_RUN;
        else if (eof) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Raster counters: free-run while live, parked at (0,0) otherwise
  always_comb begin
    h_d = 12'd0;
    v_d = 12'd0;
    if (live) begin
      h_d = h_wrap ? 12'd0 : h_q + 12'd1;
      v_d = v_q;
      if (h_wrap) v_d = (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
    end
  end

  // Output decode from the current counter state, registered one cycle later
  always_comb begin
    de_d   = live && (h_q < H_ACT) && (v_q < V_ACT);
    hs_d   = hs_in ? HS_ACT : ~HS_ACT;
    vs_d   = vs_in ? VS_ACT : ~VS_ACT;
    fs_d   = live && (h_q == 12'd0) && (v_q == 12'd0);
    busy_d = (state_q != S_IDLE);
    px_d   = px_q;
    py_d   = py_q;
    if (!live) begin
      px_d = 12'd0;
      py_d = 12'd0;
    end else if (de_d) begin
      px_d = h_q;
      py_d = v_q;
    end
  end

  // State, counters and output registers
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      h_q     <= 12'd0;
      v_q     <= 12'd0;
      vs_q    <= ~VS_ACT;
      hs_q    <= ~HS_ACT;
      de_q    <= 1'b0;
      px_q    <= 12'd0;
      py_q    <= 12'd0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      vs_q    <= vs_d;
      hs_q    <= hs_d;
      de_q    <= de_d;
      px_q    <= px_d;
      py_q    <= py_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
    end
  end

  assign vs_out      = vs_q;
  assign hs_out      = hs_q;
  assign de_out      = de_q;
  assign pixel_x     = px_q;
  assign pixel_y     = py_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;

`ifdef VTG_COLORBAR_EN
  localparam int BAR_WI = (H_ACTIVE / 8) < 1 ? 1 : (H_ACTIVE / 8);
  localparam logic [11:0] BAR_LAST = 12'(BAR_WI - 1);

  logic [2:0]  bar_q, bar_d;
  logic [11:0] col_q, col_d;
  logic [23:0] rgb_q, rgb_d;

  function automatic logic [23:0] bar_color(input logic [2:0] b);
    logic [23:0] c;
    c = 24'h000000;
    unique case (b)
      3'd0: c = 24'hFFFFFF;
      3'd1: c = 24'hFFFF00;
      3'd2: c = 24'h00FFFF;
      3'd3: c = 24'h00FF00;
      3'd4: c = 24'hFF00FF;
      3'd5: c = 24'hFF0000;
      3'd6: c = 24'h0000FF;
      3'd7: c = 24'h000000;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // Bar index follows h_cnt via a per-bar column counter; last bar absorbs remainder
  always_comb begin
    bar_d = 3'd0;
    col_d = 12'd0;
    if (live && (h_d != 12'd0)) begin
      if ((bar_q != 3'd7) && (col_q == BAR_LAST)) begin
        bar_d = bar_q + 3'd1;
        col_d = 12'd0;
      end else begin
        bar_d = bar_q;
        col_d = col_q + 12'd1;
      end
    end
    rgb_d = de_d ? bar_color(bar_q) : 24'h000000;
  end

  // Colour-bar tracking and registered pixel colour
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_q <= 3'd0;
      col_q <= 12'd0;
      rgb_q <= 24'h000000;
    end else begin
      bar_q <= bar_d;
      col_q <= col_d;
      rgb_q <= rgb_d;
    end
  end

  assign rgb_out = rgb_q;
`else
`endif

endmodule
